// File: rtl/truth_table_sequencer_if.sv
// Handshake bundle between a sweep controller (master) and truth_table_sequencer (slave).
// Optional golden-check signals exist only when GOLDEN_CHECK_EN is defined.
interface truth_table_sequencer_if;
    logic       start;
    logic       abort;
    logic       x_in;
    logic       a;
    logic       b;
    logic       c;
    logic       busy;
    logic       done;
    logic [7:0] result;
`ifdef GOLDEN_CHECK_EN
    logic       mismatch;
    logic [3:0] err_cnt;

    modport master (output start, abort, x_in,
                    input  a, b, c, busy, done, result, mismatch, err_cnt);
    modport slave  (input  start, abort, x_in,
                    output a, b, c, busy, done, result, mismatch, err_cnt);
`else
    modport master (output start, abort, x_in,
                    input  a, b, c, busy, done, result);
    modport slave  (input  start, abort, x_in,
                    output a, b, c, busy, done, result);
`endif
endinterface

// File: rtl/truth_table_sequencer.sv
// Sweeps {a,b,c} through 000..111, holding each HOLD_CYCLES clocks, and packs sampled x_in into result.
// GOLDEN_CHECK_EN adds mismatch/err_cnt against x = a & ~(b ^ c); abort cancels with no backpressure.
module truth_table_sequencer #(
    parameter int HOLD_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    truth_table_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_HOLD = CNT_W'(HOLD_CYCLES - 1);

    state_t           state;
    logic [2:0]       idx;
    logic [CNT_W-1:0] hold_cnt;
    logic [2:0]       abc;
    logic             busy_q;
    logic             done_q;
    logic [7:0]       result_q;
`ifdef GOLDEN_CHECK_EN
    logic             mismatch_q;
    logic [3:0]       err_q;
    assign bus.mismatch = mismatch_q;
    assign bus.err_cnt  = err_q;
`endif

    assign bus.a      = abc[2];
    assign bus.b      = abc[1];
    assign bus.c      = abc[0];
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= 3'd0;
            hold_cnt <= '0;
            abc      <= 3'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 8'h00;
`ifdef GOLDEN_CHECK_EN
            mismatch_q <= 1'b0;
            err_q      <= 4'd0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    // start outranks a simultaneous abort outside of a sweep
                    if (bus.start) begin
                        state    <= APPLY;
                        idx      <= 3'd0;
                        hold_cnt <= '0;
                        abc      <= 3'd0;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        result_q <= 8'h00;
`ifdef GOLDEN_CHECK_EN
                        mismatch_q <= 1'b0;
                        err_q      <= 4'd0;
`endif
                    end
                end
                APPLY: begin
                    if (bus.abort) begin
                        state    <= IDLE;
                        idx      <= 3'd0;
                        hold_cnt <= '0;
                        abc      <= 3'd0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b0;
                    end else if (hold_cnt == LAST_HOLD) begin
                        result_q[idx] <= bus.x_in;
                        hold_cnt      <= '0;
`ifdef GOLDEN_CHECK_EN
                        if (bus.x_in != (abc[2] & ~(abc[1] ^ abc[0]))) begin
                            mismatch_q <= 1'b1;
                            if (err_q != 4'd8)
                                err_q <= err_q + 4'd1;
                        end
`endif
                        if (idx == 3'd7) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            idx <= idx + 3'd1;
                            abc <= idx + 3'd1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_truth_table_sequencer.sv
// Runs a HOLD_CYCLES=2 and a HOLD_CYCLES=1 sequencer side by side from shared start/abort,
// each feeding x_in from a truth table and compared every cycle with a sweep-level model.
module tb_truth_table_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       st = 1'b0;
    logic       ab = 1'b0;
    logic [7:0] tbl = 8'h00;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    truth_table_sequencer_if if2();
    truth_table_sequencer_if if1();

    assign if2.start = st;
    assign if2.abort = ab;
    assign if2.x_in  = tbl[{if2.a, if2.b, if2.c}];
    assign if1.start = st;
    assign if1.abort = ab;
    assign if1.x_in  = tbl[{if1.a, if1.b, if1.c}];

    truth_table_sequencer #(.HOLD_CYCLES(2), .CNT_W(8)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    truth_table_sequencer #(.HOLD_CYCLES(1), .CNT_W(8)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    // Model: k counts clocks spent sweeping; vector k/h is driven, sampled when (k+1)%h==0.
    typedef struct {
        bit         run;
        bit         dn;
        int         k;
        logic [7:0] res;
        int         err;
        bit         mm;
    } mdl_t;

    mdl_t m [2];
    int   hv [2] = '{2, 1};

    function automatic bit gold(int v);
        logic [2:0] t;
        t = 3'(v);
        return t[2] & ~(t[1] ^ t[0]);
    endfunction

    function automatic void mreset(int i);
        m[i].run = 0; m[i].dn = 0; m[i].k = 0;
        m[i].res = 8'h00; m[i].err = 0; m[i].mm = 0;
    endfunction

    function automatic void mstep(int i, bit s, bit a);
        int v;
        if (!m[i].run) begin
            if (s) begin
                m[i].run = 1; m[i].dn = 0; m[i].k = 0;
                m[i].res = 8'h00; m[i].err = 0; m[i].mm = 0;
            end
        end else if (a) begin
            m[i].run = 0; m[i].dn = 0; m[i].k = 0;
        end else begin
            v = m[i].k / hv[i];
            if ((m[i].k + 1) % hv[i] == 0) begin
                m[i].res[v] = tbl[v];
                if (tbl[v] != gold(v)) begin
                    m[i].mm = 1;
                    if (m[i].err < 8) m[i].err++;
                end
            end
            m[i].k++;
            if (m[i].k == 8 * hv[i]) begin
                m[i].run = 0;
                m[i].dn  = 1;
            end
        end
    endfunction

    function automatic logic [2:0] exp_abc(int i);
        if (m[i].run) return 3'(m[i].k / hv[i]);
        if (m[i].dn)  return 3'd7;
        return 3'd0;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("busy_h2",   {7'b0, if2.busy}, {7'b0, m[0].run});
        chk("done_h2",   {7'b0, if2.done}, {7'b0, m[0].dn});
        chk("abc_h2",    {5'b0, if2.a, if2.b, if2.c}, {5'b0, exp_abc(0)});
        chk("result_h2", if2.result, m[0].res);
        chk("busy_h1",   {7'b0, if1.busy}, {7'b0, m[1].run});
        chk("done_h1",   {7'b0, if1.done}, {7'b0, m[1].dn});
        chk("abc_h1",    {5'b0, if1.a, if1.b, if1.c}, {5'b0, exp_abc(1)});
        chk("result_h1", if1.result, m[1].res);
`ifdef GOLDEN_CHECK_EN
        chk("mismatch_h2", {7'b0, if2.mismatch}, {7'b0, m[0].mm});
        chk("errcnt_h2",   {4'b0, if2.err_cnt}, 8'(m[0].err));
        chk("mismatch_h1", {7'b0, if1.mismatch}, {7'b0, m[1].mm});
        chk("errcnt_h1",   {4'b0, if1.err_cnt}, 8'(m[1].err));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            mstep(0, st, ab);
            mstep(1, st, ab);
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic set_golden_table();
        for (int v = 0; v < 8; v++) tbl[v] = gold(v);
    endtask

    task automatic sweep(input int cycles);
        st = 1'b1;
        tick();
        st = 1'b0;
        repeat (cycles) tick();
    endtask

    initial begin
        mreset(0);
        mreset(1);
        set_golden_table();

        // reset state, then idle with random abort
        #1 check_all();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            ab = 1'($urandom_range(0, 1));
            tick();
        end
        ab = 1'b0;

        // correct exercise circuit
        sweep(17);
        chk("golden_result_h2", if2.result, 8'h90);
        chk("golden_result_h1", if1.result, 8'h90);

        // x tied high, start held through the H=1 sweep
        tbl = 8'hFF;
        st  = 1'b1;
        tick();
        repeat (6) tick();
        st = 1'b0;
        tick();
        chk("ones_done_h1_early", {7'b0, if1.done}, 8'h00);
        tick();
        chk("ones_done_h1", {7'b0, if1.done}, 8'h01);
        chk("ones_result_h1", if1.result, 8'hFF);
        repeat (9) tick();
        chk("ones_result_h2", if2.result, 8'hFF);

        // x tied low
        tbl = 8'h00;
        sweep(17);
        chk("zeros_result_h2", if2.result, 8'h00);

        // abort on the edge that would sample vector 5 of the H=2 sweep
        set_golden_table();
        st = 1'b1;
        tick();
        st = 1'b0;
        repeat (11) tick();
        ab = 1'b1;
        tick();
        ab = 1'b0;
        chk("abort_result_h2", if2.result, 8'h10);
        chk("abort_busy_h2", {7'b0, if2.busy}, 8'h00);
        chk("abort_abc_h2", {5'b0, if2.a, if2.b, if2.c}, 8'h00);
        repeat (3) tick();

        // restart from DONE with start and abort together
        sweep(17);
        st = 1'b1;
        ab = 1'b1;
        tick();
        st = 1'b0;
        ab = 1'b0;
        chk("restart_result_h2", if2.result, 8'h00);
        chk("restart_busy_h2", {7'b0, if2.busy}, 8'h01);
        repeat (16) tick();
        chk("restart_final_h2", if2.result, 8'h90);

        // random circuits with random aborts and restarts
        repeat (8) begin
            tbl = 8'($urandom);
            st = 1'b1;
            tick();
            st = 1'b0;
            repeat ($urandom_range(1, 20)) begin
                ab = ($urandom_range(0, 15) == 0);
                st = ($urandom_range(0, 7) == 0);
                tick();
            end
            ab = 1'b0;
            st = 1'b0;
            repeat (17) tick();
        end

        // asynchronous reset in the middle of a sweep
        set_golden_table();
        st = 1'b1;
        tick();
        st = 1'b0;
        repeat (5) tick();
        #2 rst_n = 1'b0;
        mreset(0);
        mreset(1);
        #1 check_all();
        #1 rst_n = 1'b1;
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
